// File: rtl/boreal_bus_arbiter.sv
// Two-master (CPU/DMA) request arbiter with a single outstanding downstream
// transaction, CPU priority with DMA anti-starvation, and a response watchdog.

// Per-master response register: one-cycle valid pulse, data/err held between pulses.
module boreal_resp_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= set_i;
      if (set_i) begin
        rdata_q <= rdata_i;
        err_q   <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
endmodule

module boreal_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid_i,
  input  logic        cpu_req_we_i,
  input  logic [31:0] cpu_req_addr_i,
  input  logic [31:0] cpu_req_wdata_i,
  input  logic [3:0]  cpu_req_wstrb_i,
  output logic        cpu_req_ready_o,
  output logic        cpu_resp_valid_o,
  output logic [31:0] cpu_resp_rdata_o,
  output logic        cpu_resp_err_o,
  input  logic        dma_req_valid_i,
  input  logic        dma_req_we_i,
  input  logic [31:0] dma_req_addr_i,
  input  logic [31:0] dma_req_wdata_i,
  input  logic [3:0]  dma_req_wstrb_i,
  output logic        dma_req_ready_o,
  output logic        dma_resp_valid_o,
  output logic [31:0] dma_resp_rdata_o,
  output logic        dma_resp_err_o,
  output logic        m_req_valid_o,
  output logic        m_req_we_o,
  output logic [31:0] m_req_addr_o,
  output logic [31:0] m_req_wdata_o,
  output logic [3:0]  m_req_wstrb_o,
  input  logic        m_resp_valid_i,
  input  logic [31:0] m_resp_rdata_i,
  input  logic        m_resp_err_i,
  output logic        arb_busy_o,
  output logic        arb_timeout_o
);
  localparam int unsigned NUM_M      = 2;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] wait_q, wait_d;
  logic       owner_q, owner_d;
  req_t       mreq_q, mreq_d;
  logic       mvld_q, mvld_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;

  // Master index 0 is the CPU, 1 is the DMA; owner_q holds that index.
  logic [NUM_M-1:0]        req_valid;
  req_t [NUM_M-1:0]        req;
  logic [NUM_M-1:0]        resp_set;
  logic [31:0]             resp_rdata;
  logic                    resp_err;
  logic [NUM_M-1:0]        lane_valid;
  logic [NUM_M-1:0][31:0]  lane_rdata;
  logic [NUM_M-1:0]        lane_err;

  logic idle, starved, grant_cpu, grant_dma, accept;

  assign req_valid = {dma_req_valid_i, cpu_req_valid_i};
  assign req[0]    = {cpu_req_we_i, cpu_req_addr_i, cpu_req_wdata_i, cpu_req_wstrb_i};
  assign req[1]    = {dma_req_we_i, dma_req_addr_i, dma_req_wdata_i, dma_req_wstrb_i};

  assign idle      = (state_q == ST_IDLE);
  assign starved   = (starve_q == STARVE_LIM);
  assign grant_dma = req_valid[1] && (!req_valid[0] || starved);
  assign grant_cpu = req_valid[0] && !grant_dma;
  assign accept    = idle && (grant_cpu || grant_dma);

  assign cpu_req_ready_o = idle && grant_cpu;
  assign dma_req_ready_o = idle && grant_dma;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wait_d     = wait_q;
    owner_d    = owner_q;
    mreq_d     = mreq_q;
    mvld_d     = 1'b0;
    tmo_d      = tmo_q;
    resp_set   = '0;
    resp_rdata = m_resp_rdata_i;
    resp_err   = m_resp_err_i;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          mvld_d  = 1'b1;
          owner_d = grant_dma;
          mreq_d  = grant_dma ? req[1] : req[0];
          if (grant_dma || !req_valid[1]) starve_d = '0;
          else if (!starved)              starve_d = starve_q + 4'd1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        // A response in the final watchdog cycle takes precedence over the timeout.
        if (m_resp_valid_i) begin
          resp_set[owner_q] = 1'b1;
          state_d           = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          resp_set[owner_q] = 1'b1;
          resp_rdata        = '0;
          resp_err          = 1'b1;
          tmo_d             = 1'b1;
          state_d           = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      owner_q  <= 1'b0;
      mreq_q   <= '0;
      mvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      owner_q  <= owner_d;
      mreq_q   <= mreq_d;
      mvld_q   <= mvld_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_lane
    boreal_resp_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_i   (resp_set[i]),
      .rdata_i (resp_rdata),
      .err_i   (resp_err),
      .valid_o (lane_valid[i]),
      .rdata_o (lane_rdata[i]),
      .err_o   (lane_err[i])
    );
  end

  assign cpu_resp_valid_o = lane_valid[0];
  assign cpu_resp_rdata_o = lane_rdata[0];
  assign cpu_resp_err_o   = lane_err[0];
  assign dma_resp_valid_o = lane_valid[1];
  assign dma_resp_rdata_o = lane_rdata[1];
  assign dma_resp_err_o   = lane_err[1];

  assign m_req_valid_o = mvld_q;
  assign m_req_we_o    = mreq_q.we;
  assign m_req_addr_o  = mreq_q.addr;
  assign m_req_wdata_o = mreq_q.wdata;
  assign m_req_wstrb_o = mreq_q.wstrb;
  assign arb_busy_o    = busy_q;
  assign arb_timeout_o = tmo_q;
endmodule

// File: tb/tb_boreal_bus_arbiter.sv
// Self-checking bench: bench-side master agents and downstream responder, with a
// transaction-level timing model (accept cycle -> issue/response/free cycles).
module tb_boreal_bus_arbiter;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid_i = 0, cpu_req_we_i = 0;
  logic [31:0] cpu_req_addr_i = 0, cpu_req_wdata_i = 0;
  logic [3:0]  cpu_req_wstrb_i = 0;
  logic        cpu_req_ready_o, cpu_resp_valid_o, cpu_resp_err_o;
  logic [31:0] cpu_resp_rdata_o;
  logic        dma_req_valid_i = 0, dma_req_we_i = 0;
  logic [31:0] dma_req_addr_i = 0, dma_req_wdata_i = 0;
  logic [3:0]  dma_req_wstrb_i = 0;
  logic        dma_req_ready_o, dma_resp_valid_o, dma_resp_err_o;
  logic [31:0] dma_resp_rdata_o;
  logic        m_req_valid_o, m_req_we_o;
  logic [31:0] m_req_addr_o, m_req_wdata_o;
  logic [3:0]  m_req_wstrb_o;
  logic        m_resp_valid_i = 0, m_resp_err_i = 0;
  logic [31:0] m_resp_rdata_i = 0;
  logic        arb_busy_o, arb_timeout_o;

  boreal_bus_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_we_i(cpu_req_we_i),
    .cpu_req_addr_i(cpu_req_addr_i), .cpu_req_wdata_i(cpu_req_wdata_i),
    .cpu_req_wstrb_i(cpu_req_wstrb_i), .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_resp_valid_o(cpu_resp_valid_o), .cpu_resp_rdata_o(cpu_resp_rdata_o),
    .cpu_resp_err_o(cpu_resp_err_o),
    .dma_req_valid_i(dma_req_valid_i), .dma_req_we_i(dma_req_we_i),
    .dma_req_addr_i(dma_req_addr_i), .dma_req_wdata_i(dma_req_wdata_i),
    .dma_req_wstrb_i(dma_req_wstrb_i), .dma_req_ready_o(dma_req_ready_o),
    .dma_resp_valid_o(dma_resp_valid_o), .dma_resp_rdata_o(dma_resp_rdata_o),
    .dma_resp_err_o(dma_resp_err_o),
    .m_req_valid_o(m_req_valid_o), .m_req_we_o(m_req_we_o),
    .m_req_addr_o(m_req_addr_o), .m_req_wdata_o(m_req_wdata_o),
    .m_req_wstrb_o(m_req_wstrb_o),
    .m_resp_valid_i(m_resp_valid_i), .m_resp_rdata_i(m_resp_rdata_i),
    .m_resp_err_i(m_resp_err_i),
    .arb_busy_o(arb_busy_o), .arb_timeout_o(arb_timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Master agents (0 = CPU, 1 = DMA)
  bit          pend [2];
  logic        we_p [2];
  logic [31:0] addr_p [2];
  logic [31:0] wd_p [2];
  logic [3:0]  st_p [2];
  int          rate [2];

  // Outstanding transaction in model terms
  bit          txn;
  int          t_acc, t_drive, t_done, owner;
  logic [31:0] r_data;
  bit          r_err;

  // Expected visible state
  logic [31:0] h_rdata [2];
  bit          h_err [2];
  bit          tmo;
  logic        m_we;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_st;
  int          streak;

  int          plan_mode, plan_lat;
  logic [31:0] plan_data;
  bit          plan_err;
  bit          spur_en;
  int          spur_at = -1;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outs(input bit rv0, input bit rv1);
    chk("m_req_valid", m_req_valid_o, txn && cyc == t_acc + 1);
    chk("arb_busy", arb_busy_o, txn && cyc > t_acc && cyc < t_done);
    chk("cpu_resp_valid", cpu_resp_valid_o, rv0);
    chk("dma_resp_valid", dma_resp_valid_o, rv1);
    chk("cpu_resp_rdata", cpu_resp_rdata_o, h_rdata[0]);
    chk("cpu_resp_err", cpu_resp_err_o, h_err[0]);
    chk("dma_resp_rdata", dma_resp_rdata_o, h_rdata[1]);
    chk("dma_resp_err", dma_resp_err_o, h_err[1]);
    chk("m_req_we", m_req_we_o, m_we);
    chk("m_req_addr", m_req_addr_o, m_addr);
    chk("m_req_wdata", m_req_wdata_o, m_wd);
    chk("m_req_wstrb", m_req_wstrb_o, m_st);
    chk("arb_timeout", arb_timeout_o, tmo);
  endtask

  task automatic drive_masters();
    cpu_req_valid_i = pend[0]; cpu_req_we_i = we_p[0]; cpu_req_addr_i = addr_p[0];
    cpu_req_wdata_i = wd_p[0]; cpu_req_wstrb_i = st_p[0];
    dma_req_valid_i = pend[1]; dma_req_we_i = we_p[1]; dma_req_addr_i = addr_p[1];
    dma_req_wdata_i = wd_p[1]; dma_req_wstrb_i = st_p[1];
  endtask

  task automatic post(input int m, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    pend[m] = 1; we_p[m] = we; addr_p[m] = a; wd_p[m] = d; st_p[m] = s;
  endtask

  task automatic tick();
    bit rv0, rv1, rdy0, rdy1, g_dma;
    int lat;
    @(negedge clk);
    cyc++;
    rv0 = 0; rv1 = 0;
    if (txn && cyc == t_done) begin
      if (owner == 0) rv0 = 1; else rv1 = 1;
      h_rdata[owner] = r_data; h_err[owner] = r_err;
      if (t_drive < 0) tmo = 1;
    end
    check_outs(rv0, rv1);
    if (txn && cyc == t_done) txn = 0;

    m_resp_valid_i = 0; m_resp_rdata_i = $urandom; m_resp_err_i = 1'($urandom_range(0, 1));
    if (txn && cyc == t_drive) begin
      m_resp_valid_i = 1; m_resp_rdata_i = r_data; m_resp_err_i = r_err;
    end else if (!(txn && cyc >= t_acc + 2) &&
                 (cyc == spur_at || (spur_en && $urandom_range(0, 5) == 0))) begin
      m_resp_valid_i = 1;
    end

    for (int i = 0; i < 2; i++)
      if (!pend[i] && !(txn && owner == i) && rate[i] > 0 && $urandom_range(1, 100) <= rate[i])
        post(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    drive_masters();
    #1;
    g_dma = pend[1] && (!pend[0] || streak == SMAX);
    rdy1  = !txn && g_dma;
    rdy0  = !txn && pend[0] && !g_dma;
    chk("cpu_req_ready", cpu_req_ready_o, rdy0);
    chk("dma_req_ready", dma_req_ready_o, rdy1);
    if (rdy0 || rdy1) begin
      owner = rdy1 ? 1 : 0;
      grants.push_back(dma_req_ready_o ? 1 : 0);
      if (owner == 0) streak = pend[1] ? ((streak == SMAX) ? SMAX : streak + 1) : 0;
      else            streak = 0;
      m_we = we_p[owner]; m_addr = addr_p[owner]; m_wd = wd_p[owner]; m_st = st_p[owner];
      pend[owner] = 0;
      txn = 1; t_acc = cyc;
      case (plan_mode)
        1: begin lat = plan_lat; r_data = plan_data; r_err = plan_err; end
        2: lat = -1;
        default: begin
          lat    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
          r_data = $urandom; r_err = ($urandom_range(0, 9) == 0);
        end
      endcase
      if (lat < 0) begin t_drive = -1; t_done = cyc + 2 + TMO; r_data = 0; r_err = 1; end
      else begin t_drive = cyc + 2 + lat; t_done = t_drive + 1; end
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    pend[0] = 0; pend[1] = 0;
    drive_masters();
    m_resp_valid_i = 0;
    #1;
    txn = 0; tmo = 0; streak = 0;
    h_rdata[0] = 0; h_rdata[1] = 0; h_err[0] = 0; h_err[1] = 0;
    m_we = 0; m_addr = 0; m_wd = 0; m_st = 0;
    check_outs(0, 0);
    chk("rst_cpu_ready", cpu_req_ready_o, 0);
    chk("rst_dma_ready", dma_req_ready_o, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rate[0] = 0; rate[1] = 0; spur_en = 0; plan_mode = 1; plan_lat = 2; plan_err = 0;
    do_reset();

    // Single CPU read, fixed 2-cycle downstream latency
    plan_data = 32'hDEADBEEF;
    post(0, 0, 32'h0000_1000, 32'h0, 4'h0);
    ticks(8);
    chk("cpu_read_data", cpu_resp_rdata_o, 32'hDEADBEEF);

    // DMA-only write
    plan_data = 32'h0000_0000;
    post(1, 1, 32'h1003_0004, 32'hCAFE_F00D, 4'hF);
    ticks(8);
    chk("dma_write_addr", m_req_addr_o, 32'h1003_0004);

    // Both masters saturated: expect CPU x4 then DMA, repeating
    grants.delete();
    rate[0] = 100; rate[1] = 100;
    for (int k = 0; k < 120 && grants.size() < 10; k++) tick();
    rate[0] = 0; rate[1] = 0;
    ticks(8);
    chk("grant_count_ge10", 32'(grants.size() >= 10), 1);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      chk($sformatf("grant_order[%0d]", k), grants[k], (k % 5 == 4) ? 1 : 0);

    // Response in the last watchdog cycle wins
    plan_lat = TMO - 1; plan_data = 32'h0BAD_F00D;
    post(0, 0, 32'h0000_2000, 32'h0, 4'h0);
    ticks(TMO + 6);
    chk("last_cycle_timeout", arb_timeout_o, 0);
    chk("last_cycle_data", cpu_resp_rdata_o, 32'h0BAD_F00D);

    // Dropped response -> watchdog error, then late responses are discarded
    plan_mode = 2;
    post(0, 0, 32'h0000_3000, 32'h0, 4'h0);
    ticks(TMO + 4);
    chk("timeout_flag", arb_timeout_o, 1);
    chk("timeout_err", cpu_resp_err_o, 1);
    spur_at = cyc + 1; spur_en = 1;
    ticks(6);
    spur_en = 0;
    chk("timeout_sticky", arb_timeout_o, 1);

    // Randomized traffic with spurious idle responses
    plan_mode = 0; rate[0] = 30; rate[1] = 30; spur_en = 1;
    ticks(400);
    rate[0] = 0; rate[1] = 0;
    for (int k = 0; k < 3 * TMO && txn; k++) tick();
    chk("drain_done", 32'(txn), 0);
    spur_en = 0;

    // Reset in the middle of a transaction
    do_reset();
    plan_mode = 1; plan_lat = 2; plan_data = 32'h1234_5678;
    post(0, 0, 32'h0000_4000, 32'h0, 4'h0);
    ticks(4);
    do_reset();
    spur_at = cyc + 1;
    ticks(4);
    plan_data = 32'h8765_4321;
    post(1, 0, 32'h0000_5000, 32'h0, 4'h0);
    ticks(8);
    chk("post_reset_dma_data", dma_resp_rdata_o, 32'h8765_4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
